// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
// Op codes, FSM state encoding and the default datapath width.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_CALC = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_CALC = ST_CALC,
        S_FIX  = ST_FIX,
        S_DONE = ST_DONE
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage and the multiply/divide sequencer.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] busA;
    logic [WIDTH-1:0] busB;
    logic             cancel;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, busA, busB, cancel,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, busA, busB, cancel,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply (mode=0) or restoring divide (mode=1).
// Multiply: acc=upper product, aux=multiplier. Divide: acc=remainder, aux=quotient.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] aux,
    input  logic [WIDTH-1:0] operand,
    input  logic             mode,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] aux_next
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_s;
    logic [WIDTH:0] trial;
    logic           trial_ok;

    always_comb begin
        sum      = {1'b0, acc} + (aux[0] ? {1'b0, operand} : '0);
        rem_s    = {acc, aux[WIDTH-1]};
        trial    = rem_s - {1'b0, operand};
        // A set top bit of the shifted remainder already exceeds any divisor.
        trial_ok = rem_s[WIDTH] | ~trial[WIDTH];

        if (mode) begin
            acc_next = trial_ok ? trial[WIDTH-1:0] : rem_s[WIDTH-1:0];
            aux_next = {aux[WIDTH-2:0], trial_ok};
        end else begin
            acc_next = sum[WIDTH:1];
            aux_next = {sum[0], aux[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO and the pipeline stall.
// Optional MULDIV_SIGNED_EN: enables signed MULT/DIV (magnitude + sign fix).
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t state_reg, state_next;

    logic [WIDTH-1:0] opa_reg, opb_reg;
    logic             is_div_reg;
    logic             divz_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] acc_reg, aux_reg, operand_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;

    logic [WIDTH-1:0] step_acc, step_aux;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quot, rem;
    logic             launch;

`ifdef MULDIV_SIGNED_EN
    logic signed_reg;
    logic neg_res_reg, neg_rem_reg;
    logic sign_a, sign_b;
`endif

    assign launch = bus.start && !bus.cancel;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_reg),
        .aux      (aux_reg),
        .operand  (operand_reg),
        .mode     (is_div_reg),
        .acc_next (step_acc),
        .aux_next (step_aux)
    );

    // Operand magnitudes taken in LOAD.
`ifdef MULDIV_SIGNED_EN
    assign sign_a = signed_reg & opa_reg[WIDTH-1];
    assign sign_b = signed_reg & opb_reg[WIDTH-1];
    assign mag_a  = sign_a ? -opa_reg : opa_reg;
    assign mag_b  = sign_b ? -opb_reg : opb_reg;
`else
    assign mag_a  = opa_reg;
    assign mag_b  = opb_reg;
`endif

    // Result formation for FIX, including the optional sign correction.
    always_comb begin
        prod = {acc_reg, aux_reg};
        quot = aux_reg;
        rem  = acc_reg;
`ifdef MULDIV_SIGNED_EN
        if (neg_res_reg) begin
            prod = -prod;
            quot = -quot;
        end
        if (neg_rem_reg) begin
            rem = -rem;
        end
`endif
        if (divz_reg) begin
            fix_hi = opa_reg;
            fix_lo = '1;
        end else if (is_div_reg) begin
            fix_hi = rem;
            fix_lo = quot;
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (launch) state_next = S_LOAD;
            S_LOAD: state_next = (is_div_reg && opb_reg == '0) ? S_FIX : S_CALC;
            S_CALC: if (cnt_reg == '0) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (bus.cancel) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa_reg     <= '0;
            opb_reg     <= '0;
            is_div_reg  <= 1'b0;
            divz_reg    <= 1'b0;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            aux_reg     <= '0;
            operand_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
`ifdef MULDIV_SIGNED_EN
            signed_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (launch) begin
                        opa_reg    <= bus.busA;
                        opb_reg    <= bus.busB;
                        is_div_reg <= op_is_div(bus.op);
`ifdef MULDIV_SIGNED_EN
                        signed_reg <= op_is_signed(bus.op);
`endif
                    end
                end
                S_LOAD: begin
                    acc_reg     <= '0;
                    aux_reg     <= is_div_reg ? mag_a : mag_b;
                    operand_reg <= is_div_reg ? mag_b : mag_a;
                    cnt_reg     <= CNT_W'(WIDTH - 1);
                    divz_reg    <= is_div_reg && (opb_reg == '0);
`ifdef MULDIV_SIGNED_EN
                    neg_res_reg <= sign_a ^ sign_b;
                    neg_rem_reg <= is_div_reg & sign_a;
`endif
                end
                S_CALC: begin
                    acc_reg <= step_acc;
                    aux_reg <= step_aux;
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                S_FIX: begin
                    // A flush arriving in FIX must leave the architectural HI/LO intact.
                    if (!bus.cancel) begin
                        hi_reg <= fix_hi;
                        lo_reg <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state_reg == S_LOAD) || (state_reg == S_CALC) || (state_reg == S_FIX);
    assign bus.done  = (state_reg == S_DONE) && !bus.cancel;
    assign bus.stall = (bus.start || bus.busy) && !bus.done;
    assign bus.hi    = hi_reg;
    assign bus.lo    = lo_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, results, cancel, reset and start-while-busy.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W = 32;

`ifdef MULDIV_SIGNED_EN
    localparam logic [W-1:0] MULT_HI  = 32'hFFFFFFFF;
    localparam logic [W-1:0] DIV_LO   = 32'hFFFFFFFD;
    localparam logic [W-1:0] DIV_HI   = 32'hFFFFFFFF;
    localparam logic [W-1:0] OVF_LO   = 32'h80000000;
    localparam logic [W-1:0] OVF_HI   = 32'h00000000;
`else
    localparam logic [W-1:0] MULT_HI  = 32'h00000006;
    localparam logic [W-1:0] DIV_LO   = 32'h7FFFFFFC;
    localparam logic [W-1:0] DIV_HI   = 32'h00000001;
    localparam logic [W-1:0] OVF_LO   = 32'h00000000;
    localparam logic [W-1:0] OVF_HI   = 32'h80000000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   done_count = 0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_count++;
    end

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int cycles, output int stall_cycles, output logic stall_at_done);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.busA  = a;
        bus.busB  = b;
        #1;
        stall_cycles = (bus.stall === 1'b1) ? 1 : 0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        #1;
        cycles = 1;
        while (bus.done !== 1'b1 && cycles < 100) begin
            if (bus.stall === 1'b1) stall_cycles++;
            @(posedge clk);
            #1;
            cycles++;
        end
        stall_at_done = bus.stall;
        @(posedge clk);
        #1;
        $display("op=%b a=%h b=%h cycles=%0d hi=%h lo=%h", op, a, b, cycles, bus.hi, bus.lo);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", bus.stall); end
        total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", bus.hi); end
        total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", bus.lo); end
        @(negedge clk);
        rst = 1'b0;
        $display("reset checked");
    endtask

    task automatic test_multu();
        int cyc, stc;
        logic sd;
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, stc, sd);
        total++; if (cyc != 35) begin bad++; $display("FAIL multu_latency got=%0d want=35", cyc); end
        total++; if (stc != 35) begin bad++; $display("FAIL multu_stall_cycles got=%0d want=35", stc); end
        total++; if (sd !== 1'b0) begin bad++; $display("FAIL multu_stall_at_done got=%b want=0", sd); end
        total++; if (bus.hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_hi got=%h want=fffffffe", bus.hi); end
        total++; if (bus.lo !== 32'h00000001) begin bad++; $display("FAIL multu_lo got=%h want=00000001", bus.lo); end
    endtask

    task automatic test_mult();
        int cyc, stc;
        logic sd;
        run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, cyc, stc, sd);
        total++; if (bus.hi !== MULT_HI) begin bad++; $display("FAIL mult_hi got=%h want=%h", bus.hi, MULT_HI); end
        total++; if (bus.lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL mult_lo got=%h want=ffffffeb", bus.lo); end
    endtask

    task automatic test_div();
        int cyc, stc;
        logic sd;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, cyc, stc, sd);
        total++; if (cyc != 35) begin bad++; $display("FAIL div_latency got=%0d want=35", cyc); end
        total++; if (bus.lo !== DIV_LO) begin bad++; $display("FAIL div_lo got=%h want=%h", bus.lo, DIV_LO); end
        total++; if (bus.hi !== DIV_HI) begin bad++; $display("FAIL div_hi got=%h want=%h", bus.hi, DIV_HI); end
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cyc, stc, sd);
        total++; if (bus.lo !== OVF_LO) begin bad++; $display("FAIL div_ovf_lo got=%h want=%h", bus.lo, OVF_LO); end
        total++; if (bus.hi !== OVF_HI) begin bad++; $display("FAIL div_ovf_hi got=%h want=%h", bus.hi, OVF_HI); end
        run_op(OP_DIVU, 32'd1000, 32'd7, cyc, stc, sd);
        total++; if (bus.lo !== 32'd142) begin bad++; $display("FAIL divu_lo got=%h want=%h", bus.lo, 32'd142); end
        total++; if (bus.hi !== 32'd6) begin bad++; $display("FAIL divu_hi got=%h want=%h", bus.hi, 32'd6); end
    endtask

    task automatic test_divzero();
        int cyc, stc;
        logic sd;
        run_op(OP_DIVU, 32'd100, 32'd0, cyc, stc, sd);
        total++; if (cyc != 3) begin bad++; $display("FAIL divz_latency got=%0d want=3", cyc); end
        total++; if (bus.lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL divz_lo got=%h want=ffffffff", bus.lo); end
        total++; if (bus.hi !== 32'd100) begin bad++; $display("FAIL divz_hi got=%h want=%h", bus.hi, 32'd100); end
        run_op(OP_DIV, 32'hFFFFFFFB, 32'd0, cyc, stc, sd);
        total++; if (cyc != 3) begin bad++; $display("FAIL divz_s_latency got=%0d want=3", cyc); end
        total++; if (bus.lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL divz_s_lo got=%h want=ffffffff", bus.lo); end
        total++; if (bus.hi !== 32'hFFFFFFFB) begin bad++; $display("FAIL divz_s_hi got=%h want=fffffffb", bus.hi); end
    endtask

    task automatic test_cancel();
        int cyc, stc, dc;
        logic sd;
        run_op(OP_DIVU, 32'd65, 32'd10, cyc, stc, sd);
        total++; if (bus.lo !== 32'd6 || bus.hi !== 32'd5) begin
            bad++; $display("FAIL cancel_preload got=%h/%h want=5/6", bus.hi, bus.lo);
        end
        dc = done_count;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULTU; bus.busA = 32'd3; bus.busB = 32'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL cancel_busy_before got=%b want=1", bus.busy); end
        bus.cancel = 1'b1;
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL cancel_busy_after got=%b want=0", bus.busy); end
        total++; if (bus.hi !== 32'd5) begin bad++; $display("FAIL cancel_hi got=%h want=5", bus.hi); end
        total++; if (bus.lo !== 32'd6) begin bad++; $display("FAIL cancel_lo got=%h want=6", bus.lo); end
        repeat (40) @(posedge clk);
        #1;
        total++; if (done_count != dc) begin bad++; $display("FAIL cancel_no_done got=%0d want=0", done_count - dc); end
        $display("cancel: hi=%h lo=%h extra_done=%0d", bus.hi, bus.lo, done_count - dc);
        run_op(OP_MULTU, 32'd3, 32'd4, cyc, stc, sd);
        total++; if (cyc != 35) begin bad++; $display("FAIL cancel_restart_latency got=%0d want=35", cyc); end
        total++; if (bus.lo !== 32'd12 || bus.hi !== 32'd0) begin
            bad++; $display("FAIL cancel_restart_result got=%h/%h want=0/c", bus.hi, bus.lo);
        end
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.busA = 32'd1000; bus.busB = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b want=1", bus.busy); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
        total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL rstmid_hi got=%h want=0", bus.hi); end
        total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL rstmid_lo got=%h want=0", bus.lo); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", bus.done); end
        @(negedge clk);
        rst = 1'b0;
        $display("reset mid-op: hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
    endtask

    task automatic test_back_to_back();
        int cyc, dc;
        dc = done_count;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULTU; bus.busA = 32'd6; bus.busB = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 1;
        repeat (4) @(posedge clk);
        cyc += 4;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.busA = 32'd9; bus.busB = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc++;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        total++; if (cyc != 35) begin bad++; $display("FAIL b2b_latency got=%0d want=35", cyc); end
        total++; if (bus.lo !== 32'd42) begin bad++; $display("FAIL b2b_lo got=%h want=%h", bus.lo, 32'd42); end
        total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL b2b_hi got=%h want=0", bus.hi); end
        repeat (40) @(posedge clk);
        #1;
        total++; if (done_count - dc != 1) begin bad++; $display("FAIL b2b_done_count got=%0d want=1", done_count - dc); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", bus.busy); end
        $display("start-while-busy: cycles=%0d hi=%h lo=%h dones=%0d", cyc, bus.hi, bus.lo, done_count - dc);

        dc = done_count;
        @(negedge clk);
        bus.start = 1'b1; bus.cancel = 1'b1; bus.op = OP_MULTU; bus.busA = 32'd2; bus.busB = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.cancel = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL start_cancel_busy got=%b want=0", bus.busy); end
        repeat (40) @(posedge clk);
        #1;
        total++; if (done_count != dc || bus.lo !== 32'd42) begin
            bad++; $display("FAIL start_cancel_launch got=dones %0d lo %h want=dones 0 lo 2a", done_count - dc, bus.lo);
        end
        $display("start+cancel in idle: busy=%b lo=%h", bus.busy, bus.lo);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = OP_MULTU;
        bus.busA   = '0;
        bus.busB   = '0;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_divzero();
        test_cancel();
        test_rst_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
